// File: rtl/syn_row_sequencer_pkg.sv
// Shared types for the synapse row sequencer:
// sequence-word layout, array ops, FSM states and mask helpers.
package Syn_seq_pkg;

    localparam int OP_LSB   = 0;
    localparam int OP_MSB   = 1;
    localparam int ROWS_LSB = 2;
    localparam int ROWS_MSB = 9;
    localparam int MASK_LSB = 10;
    localparam int MASK_MSB = 13;
    localparam int CHAN_BIT = 14;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_EVAL  = 2'b10,
        OP_BAD   = 2'b11
    } syn_op_e;

    typedef struct packed {
        logic [16:0] rsvd;
        logic        channel;
        logic [3:0]  mask;
        logic [7:0]  rows_m1;
        logic [1:0]  op;
    } seq_word_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_REQ,
        S_RESULT,
        S_NEXT,
        S_ABORT
    } state_e;

    // An empty eval mask means "all four patterns".
    function automatic logic [3:0] eff_mask(input logic [3:0] m);
        return (m == 4'd0) ? 4'hF : m;
    endfunction

    // Index of the lowest set bit; 3 when none is set.
    function automatic logic [1:0] lowest_idx(input logic [3:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else           return 2'd3;
    endfunction

endpackage

// File: rtl/syn_row_sequencer_pattern_iter.sv
// Eval pattern iterator: next enabled index above the
// current one, and a flag when no enabled index remains.
module syn_pattern_iter
    import Syn_seq_pkg::*;
(
    input  logic [3:0] mask_i,
    input  logic [1:0] idx_i,
    output logic [1:0] next_o,
    output logic       last_o
);

    logic [3:0] above;

    // Keep only enabled bits strictly above idx_i, pick the lowest.
    always_comb begin
        above  = mask_i & ~((4'd2 << idx_i) - 4'd1);
        last_o = (above == 4'd0);
        next_o = last_o ? idx_i : lowest_idx(above);
    end

endmodule

// File: rtl/syn_row_sequencer.sv
// Walks a range of synapse rows, issuing read/write/eval
// requests to the array and returning tagged results.
module syn_row_sequencer
    import Syn_seq_pkg::*;
#(
    parameter int DATA_WIDTH     = 128,
    parameter int ADDR_WIDTH     = 16,
    parameter int SETUP_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [31:0]           seq,
    input  logic [31:0]           addr,
    input  logic [DATA_WIDTH-1:0] client2syn_data,
    input  logic [15:0]           client2syn_patterns,
    output logic                  busy,
    output logic                  error,
    output logic                  syn_req,
    output logic [1:0]            syn_op,
    output logic [ADDR_WIDTH-1:0] syn_addr,
    output logic [3:0]            syn_pattern,
    output logic [DATA_WIDTH-1:0] syn_wdata,
    input  logic                  syn_ack,
    input  logic [DATA_WIDTH-1:0] syn_rdata,
    output logic                  syn2client_valid,
    output logic [DATA_WIDTH-1:0] syn2client_data,
    output logic                  syn2client_channel,
    output logic [1:0]            syn2client_pat_ctr
);

    localparam logic [7:0] SETUP_LD = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] TO_LAST  = 8'(TIMEOUT_CYCLES - 1);

    state_e                state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [7:0]            rows_q, rows_d;
    syn_op_e               op_q, op_d;
    logic [3:0]            mask_q, mask_d;
    logic                  chan_q, chan_d;
    logic [ADDR_WIDTH-1:0] row_q, row_d;
    logic [1:0]            idx_q, idx_d;
    logic [15:0]           pats_q, pats_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    seq_word_t             sw;
    logic                  legal;
    logic                  is_eval;
    logic [1:0]            idx_nxt;
    logic                  idx_last;
    logic                  more_pat;
    logic                  unused_bits;

    assign sw          = seq;
    assign legal       = (sw.op != OP_BAD);
    assign is_eval     = (op_q == OP_EVAL);
    assign more_pat    = is_eval && !idx_last;
    assign unused_bits = ^{sw.rsvd, addr[31:ADDR_WIDTH]};

    syn_pattern_iter u_iter (
        .mask_i (mask_q),
        .idx_i  (idx_q),
        .next_o (idx_nxt),
        .last_o (idx_last)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start && legal) state_d = S_SETUP;
            end
            S_SETUP: begin
                if (cnt_q == 8'd0) state_d = S_REQ;
            end
            S_REQ: begin
                if (syn_ack) begin
                    state_d = (op_q == OP_WRITE) ? S_NEXT : S_RESULT;
                end else if (cnt_q == TO_LAST) begin
                    state_d = S_ABORT;
                end
            end
            S_RESULT: state_d = S_NEXT;
            S_NEXT: begin
                if (more_pat || rows_q != 8'd0) state_d = S_REQ;
                else                            state_d = S_IDLE;
            end
            S_ABORT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs, gated so nothing leaks outside its own state.
    always_comb begin
        busy               = (state_q != S_IDLE);
        error              = (state_q == S_ABORT);
        syn_req            = (state_q == S_REQ);
        syn_op             = syn_req ? op_q : 2'b00;
        syn_addr           = syn_req ? row_q : '0;
        syn_pattern        = (syn_req && is_eval)
                             ? pats_q[{~idx_q, 2'b11} -: 4] : 4'd0;
        syn_wdata          = (syn_req && op_q == OP_WRITE)
                             ? wdata_q : '0;
        syn2client_valid   = (state_q == S_RESULT);
        syn2client_data    = syn2client_valid ? rdata_q : '0;
        syn2client_channel = syn2client_valid && chan_q;
        syn2client_pat_ctr = syn2client_valid ? idx_q : 2'd0;
    end

    // Datapath next-state: latch the sequence, walk rows/patterns.
    always_comb begin
        cnt_d   = cnt_q;
        rows_d  = rows_q;
        op_d    = op_q;
        mask_d  = mask_q;
        chan_d  = chan_q;
        row_d   = row_q;
        idx_d   = idx_q;
        pats_d  = pats_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (start && legal) begin
                    cnt_d  = SETUP_LD;
                    rows_d = sw.rows_m1;
                    op_d   = syn_op_e'(sw.op);
                    mask_d = eff_mask(sw.mask);
                    chan_d = sw.channel;
                    row_d  = addr[ADDR_WIDTH-1:0];
                    pats_d = client2syn_patterns;
                    idx_d  = (sw.op == OP_EVAL)
                             ? lowest_idx(eff_mask(sw.mask)) : 2'd0;
                end
            end
            S_SETUP: begin
                if (cnt_q == 8'd0) begin
                    wdata_d = client2syn_data;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + 8'd1;
                if (syn_ack) rdata_d = syn_rdata;
            end
            S_NEXT: begin
                cnt_d   = 8'd0;
                wdata_d = client2syn_data;
                if (more_pat) begin
                    idx_d = idx_nxt;
                end else if (rows_q != 8'd0) begin
                    rows_d = rows_q - 8'd1;
                    row_d  = row_q + 1'b1;
                    idx_d  = is_eval ? lowest_idx(mask_q) : 2'd0;
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= 8'd0;
            rows_q  <= 8'd0;
            op_q    <= OP_READ;
            mask_q  <= 4'd0;
            chan_q  <= 1'b0;
            row_q   <= '0;
            idx_q   <= 2'd0;
            pats_q  <= 16'd0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            rows_q  <= rows_d;
            op_q    <= op_d;
            mask_q  <= mask_d;
            chan_q  <= chan_d;
            row_q   <= row_d;
            idx_q   <= idx_d;
            pats_q  <= pats_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_syn_row_sequencer.sv
// Directed bench for syn_row_sequencer: latency, row walk,
// eval pattern order, timeout, ignored starts and reset abort.
module tb_syn_row_sequencer;

    localparam int DW = 128;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [31:0]   seq = '0;
    logic [31:0]   addr = '0;
    logic [DW-1:0] c_data = '0;
    logic [15:0]   pats = '0;
    logic          syn_ack = 1'b0;
    logic [DW-1:0] syn_rdata = '0;

    logic          busy, error, syn_req;
    logic [1:0]    syn_op;
    logic [AW-1:0] syn_addr;
    logic [3:0]    syn_pattern;
    logic [DW-1:0] syn_wdata;
    logic          r_valid;
    logic [DW-1:0] r_data;
    logic          r_chan;
    logic [1:0]    r_ctr;

    int checks = 0;
    int errors = 0;

    syn_row_sequencer #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .SETUP_CYCLES(2), .TIMEOUT_CYCLES(255)
    ) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .start               (start),
        .seq                 (seq),
        .addr                (addr),
        .client2syn_data     (c_data),
        .client2syn_patterns (pats),
        .busy                (busy),
        .error               (error),
        .syn_req             (syn_req),
        .syn_op              (syn_op),
        .syn_addr            (syn_addr),
        .syn_pattern         (syn_pattern),
        .syn_wdata           (syn_wdata),
        .syn_ack             (syn_ack),
        .syn_rdata           (syn_rdata),
        .syn2client_valid    (r_valid),
        .syn2client_data     (r_data),
        .syn2client_channel  (r_chan),
        .syn2client_pat_ctr  (r_ctr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_seq(input logic [31:0] s,
                             input logic [31:0] a);
        seq   = s;
        addr  = a;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (syn_req !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_req"}, DW'(syn_req), DW'(1'b1));
    endtask

    // Wait for a request, check it, ack it in the same cycle.
    task automatic serve(input string tag,
                         input logic [1:0] op,
                         input logic [AW-1:0] row,
                         input logic [3:0] pat,
                         input logic [DW-1:0] wd,
                         input logic [DW-1:0] rd);
        wait_req(tag);
        chk({tag, "_op"}, DW'(syn_op), DW'(op));
        chk({tag, "_addr"}, DW'(syn_addr), DW'(row));
        if (op == 2'b10) chk({tag, "_pat"}, DW'(syn_pattern), DW'(pat));
        if (op == 2'b01) chk({tag, "_wdata"}, syn_wdata, wd);
        syn_ack   = 1'b1;
        syn_rdata = rd;
        tick();
        syn_ack   = 1'b0;
        syn_rdata = '0;
        chk({tag, "_reqdrop"}, DW'(syn_req), DW'(1'b0));
    endtask

    task automatic result(input string tag,
                          input logic [DW-1:0] d,
                          input logic ch,
                          input logic [1:0] ctr);
        chk({tag, "_valid"}, DW'(r_valid), DW'(1'b1));
        chk({tag, "_data"}, r_data, d);
        chk({tag, "_chan"}, DW'(r_chan), DW'(ch));
        chk({tag, "_ctr"}, DW'(r_ctr), DW'(ctr));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] e_row [4];
        logic [3:0]    e_pat [4];
        logic [1:0]    e_ctr [4];
        logic [DW-1:0] rd;

        // Reset state
        tick();
        tick();
        chk("rst_busy", DW'(busy), '0);
        chk("rst_req", DW'(syn_req), '0);
        chk("rst_valid", DW'(r_valid), '0);
        chk("rst_error", DW'(error), '0);
        chk("rst_addr", DW'(syn_addr), '0);
        reset_n = 1'b1;
        tick();

        // Single-row read, exact latency
        start_seq(32'h0, 32'h10);
        chk("rd_busy_c1", DW'(busy), DW'(1'b1));
        chk("rd_req_c1", DW'(syn_req), '0);
        tick();
        chk("rd_req_c2", DW'(syn_req), '0);
        tick();
        chk("rd_req_c3", DW'(syn_req), DW'(1'b1));
        rd = {4{32'hCAFE_0010}};
        serve("rd", 2'b00, 16'h0010, 4'd0, '0, rd);
        result("rd", rd, 1'b0, 2'd0);
        tick();
        chk("rd_valid_c5", DW'(r_valid), '0);
        chk("rd_busy_c5", DW'(busy), DW'(1'b1));
        tick();
        chk("rd_busy_c6", DW'(busy), '0);

        // Three-row write with wrap; start while busy ignored
        c_data = {4{32'h1111_0000}};
        start_seq(32'h0000_0009, 32'h0000_FFFF);
        serve("wr0", 2'b01, 16'hFFFF, 4'd0, {4{32'h1111_0000}}, '0);
        chk("wr0_novalid", DW'(r_valid), '0);
        c_data = {4{32'h2222_0001}};
        seq    = 32'h0;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        serve("wr1", 2'b01, 16'h0000, 4'd0, {4{32'h2222_0001}}, '0);
        chk("wr1_novalid", DW'(r_valid), '0);
        c_data = {4{32'h3333_0002}};
        serve("wr2", 2'b01, 16'h0001, 4'd0, {4{32'h3333_0002}}, '0);
        chk("wr2_busy", DW'(busy), DW'(1'b1));
        tick();
        chk("wr_done_busy", DW'(busy), '0);
        tick();
        chk("wr_no_extra_req", DW'(syn_req), '0);

        // Eval, mask 0101, 2 rows, channel 1
        pats = 16'h965A;
        e_row = '{16'h0020, 16'h0020, 16'h0021, 16'h0021};
        e_pat = '{4'b1001, 4'b0101, 4'b1001, 4'b0101};
        e_ctr = '{2'd0, 2'd2, 2'd0, 2'd2};
        start_seq(32'h0000_5406, 32'h20);
        for (int i = 0; i < 4; i++) begin
            rd = {4{32'hE000_0000 | 32'(i)}};
            serve($sformatf("ev%0d", i), 2'b10, e_row[i], e_pat[i],
                  '0, rd);
            result($sformatf("ev%0d", i), rd, 1'b1, e_ctr[i]);
        end
        tick();
        tick();
        chk("ev_done_busy", DW'(busy), '0);

        // Eval, mask 0000 means all four patterns
        pats = 16'h1234;
        start_seq(32'h0000_0002, 32'h30);
        for (int i = 0; i < 4; i++) begin
            rd = {4{32'hA000_0000 | 32'(i)}};
            serve($sformatf("em%0d", i), 2'b10, 16'h0030,
                  4'(i + 1), '0, rd);
            result($sformatf("em%0d", i), rd, 1'b0, 2'(i));
        end
        tick();
        tick();
        chk("em_done_busy", DW'(busy), '0);

        // Ack timeout
        start_seq(32'h0, 32'h40);
        wait_req("to");
        for (int i = 0; i < 254; i++) tick();
        chk("to_err_early", DW'(error), '0);
        chk("to_req_held", DW'(syn_req), DW'(1'b1));
        tick();
        chk("to_err_pulse", DW'(error), DW'(1'b1));
        chk("to_req_drop", DW'(syn_req), '0);
        chk("to_novalid", DW'(r_valid), '0);
        tick();
        chk("to_err_end", DW'(error), '0);
        chk("to_busy_end", DW'(busy), '0);
        start_seq(32'h0, 32'h50);
        chk("to_restart_busy", DW'(busy), DW'(1'b1));
        rd = {4{32'h5050_5050}};
        serve("to_rd", 2'b00, 16'h0050, 4'd0, '0, rd);
        result("to_rd", rd, 1'b0, 2'd0);
        tick();
        tick();
        chk("to_rd_idle", DW'(busy), '0);

        // Illegal op ignored
        start_seq(32'h0000_0003, 32'h60);
        chk("bad_busy", DW'(busy), '0);
        tick();
        tick();
        chk("bad_busy2", DW'(busy), '0);
        chk("bad_req", DW'(syn_req), '0);

        // Reset during REQ aborts immediately
        start_seq(32'h0, 32'h70);
        wait_req("rs");
        #2 reset_n = 1'b0;
        #1;
        chk("rs_req", DW'(syn_req), '0);
        chk("rs_busy", DW'(busy), '0);
        chk("rs_addr", DW'(syn_addr), '0);
        chk("rs_valid", DW'(r_valid), '0);
        chk("rs_error", DW'(error), '0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        tick();
        chk("rs_idle_busy", DW'(busy), '0);
        chk("rs_idle_valid", DW'(r_valid), '0);
        chk("rs_idle_error", DW'(error), '0);
        start_seq(32'h0, 32'h80);
        rd = {4{32'h8080_8080}};
        serve("rs_rd", 2'b00, 16'h0080, 4'd0, '0, rd);
        result("rs_rd", rd, 1'b0, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/syn_row_sequencer.md
Name: syn_row_sequencer

Overview:
- Sequences one synapse-array operation (row read, row write or pattern evaluation) over a range of rows.
- Sits between the synapse functional unit and the synapse array bus.
- Accepts a start pulse with a sequence word and a start address, and walks the rows, issuing array requests with a req/ack handshake.
- Returns per-row read/eval results to the client together with channel and pattern counter tags.

Parameters:
- DATA_WIDTH, 128, width of one synapse row in bits.
- ADDR_WIDTH, 16, row address width; row address wraps modulo 2^ADDR_WIDTH.
- SETUP_CYCLES, 2, idle cycles between sequence acceptance and the first array request (range 1..15).
- TIMEOUT_CYCLES, 255, maximum cycles to wait for syn_ack before aborting (range 1..255).

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous reset, active low
- start  in  1  start request; sampled only in IDLE
- seq  in  32  sequence word (encoding below)
- addr  in  32  start row; bits [ADDR_WIDTH-1:0] used
- client2syn_data  in  DATA_WIDTH  write data, sampled at every write request
- client2syn_patterns  in  16  four 4-bit eval patterns; pattern 0 is in [15:12]
- busy  out  1  sequence in progress
- error  out  1  one-cycle pulse on ack timeout
- syn_req  out  1  array request
- syn_op  out  2  00 read, 01 write, 10 eval
- syn_addr  out  ADDR_WIDTH  row address
- syn_pattern  out  4  eval pattern for the current request
- syn_wdata  out  DATA_WIDTH  write data
- syn_ack  in  1  array acknowledge; read/eval data valid in the same cycle
- syn_rdata  in  DATA_WIDTH  read/eval data
- syn2client_valid  out  1  result strobe
- syn2client_data  out  DATA_WIDTH  result row
- syn2client_channel  out  1  channel tag
- syn2client_pat_ctr  out  2  pattern index of the result (0 for read)

Behaviour:
- Sequence word fields:
  - seq[1:0]: op. Value 11 is illegal: start is ignored, busy stays 0.
  - seq[9:2]: number of rows minus 1 (1..256 rows).
  - seq[13:10]: eval pattern mask; bit 10 enables pattern 0. A mask of 0000 is treated as 1111. Ignored for read/write.
  - seq[14]: channel.
  - seq[31:15]: ignored.
- On start in IDLE: latch op, count, mask, channel and start row. busy goes to 1 the next cycle.
- State machine:
  - IDLE: busy=0. On start with a legal op, go to SETUP with the counter loaded to SETUP_CYCLES-1.
  - SETUP: counts down; at 0 go to REQ.
  - REQ: syn_req=1 with syn_op, syn_addr, syn_pattern and syn_wdata stable until ack.
    - On syn_ack with a read/eval op: capture syn_rdata and go to RESULT.
    - On syn_ack with a write op: go to NEXT.
    - If TIMEOUT_CYCLES cycles pass without ack: pulse error for 1 cycle, go to IDLE, deassert busy.
  - RESULT: syn2client_valid=1 for exactly 1 cycle with the captured data, the channel and the pattern index; then go to NEXT.
  - NEXT:
    - Eval: advance to the next enabled pattern (ascending order) and go to REQ.
    - Past the last pattern, or for read/write: if rows remain, increment the row (wrap 2^ADDR_WIDTH-1 -> 0), reset the pattern pointer to the lowest enabled bit, and go to REQ (no second SETUP).
    - Otherwise go to IDLE.
- busy deasserts in the cycle IDLE is entered. A new start is accepted in that same IDLE cycle.
- start while busy is ignored; queuing is the client's job.
- syn_req drops in the cycle after ack. There are no back-to-back requests without a NEXT cycle.
- Minimum latency, single-row read with SETUP_CYCLES=2 and start in cycle 0:
  - busy=1 in cycle 1; syn_req in cycle 3.
  - With ack in cycle 3: syn2client_valid in cycle 4, IDLE in cycle 6.
- Reset values: all outputs 0; state IDLE; counters 0.
- Asserting reset_n low mid-sequence aborts it immediately. No result or error is emitted.
- syn_ack outside REQ is ignored.

Decomposition:
- Shared package Syn_seq_pkg holds:
  - Syn_op enum (READ, WRITE, EVAL).
  - Seq_word packed struct matching the field layout above.
  - State enum.
  - Localparams for field positions.
- One sub-module, syn_pattern_iter, is natural. It takes the pattern mask and the current index and produces the next enabled index and a "last" flag, purely combinationally.

Test Plan:
- Read, seq=0x0000_0000, addr=0x10, ack 1 cycle after req -> one syn_req at row 0x10, op 00; syn2client_valid once with data=syn_rdata, pat_ctr=0; busy spans cycles 1..5.
- Write, 3 rows (seq[9:2]=2), addr=0xFFFF -> requests at rows 0xFFFF, 0x0000, 0x0001; no syn2client_valid; syn_wdata matches client2syn_data sampled at each req.
- Eval, mask 0101, 2 rows, patterns=0x965A -> 4 requests with (row, pattern) = (r,1001), (r,0101), (r+1,1001), (r+1,0101); pat_ctr sequence 0,2,0,2.
- Eval, mask 0000 -> 4 requests per row with patterns 0..3.
- Timeout: syn_ack held 0 -> error pulses exactly at req_start+255; busy=0 next cycle; subsequent start accepted normally.
- start with op=11, and start while busy -> both ignored, no req. reset_n low during REQ -> all outputs 0 asynchronously; after release the block is IDLE.
